issueque_int: RTL

- Integer issue queue, sits directly upstream of the issue/execute stage.
- Holds dispatched integer ALU ops and snoops the CDB to wake up pending operands.
- Selects the oldest entry whose operands are both valid and presents it on the issueint_* interface.
- Removes that entry when the issue stage returns issueint_equeueint_done.

---
 rtl/issueque_int.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/issueque_int.sv
// Integer issue queue: compacting, oldest-first select, CDB wakeup.
// Dispatch can capture a same-cycle CDB broadcast directly.
module issueque_int #(
  parameter int DEPTH  = 4,
  parameter int OP_W   = 6,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         dispatch_en,
  input  logic [OP_W-1:0]              dispatch_opcode,
  input  logic [DATA_W-1:0]            dispatch_rsdata,
  input  logic                         dispatch_rsvalid,
  input  logic [TAG_W-1:0]             dispatch_rstag,
  input  logic [DATA_W-1:0]            dispatch_rtdata,
  input  logic                         dispatch_rtvalid,
  input  logic [TAG_W-1:0]             dispatch_rttag,
  input  logic [TAG_W-1:0]             dispatch_rdtag,
  output logic                         issueque_full,
  output logic [$clog2(DEPTH+1)-1:0]   issueque_count,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [DATA_W-1:0]            cdb_data,
  output logic                         issueint_ready,
  output logic [OP_W-1:0]              issueint_opcode,
  output logic [DATA_W-1:0]            issueint_rsdata,
  output logic [DATA_W-1:0]            issueint_rtdata,
  output logic [TAG_W-1:0]             issueint_rdtag,
  input  logic                         issueint_equeueint_done
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] rsdata;
    logic              rsvalid;
    logic [TAG_W-1:0]  rstag;
    logic [DATA_W-1:0] rtdata;
    logic              rtvalid;
    logic [TAG_W-1:0]  rttag;
    logic [TAG_W-1:0]  rdtag;
  } entry_t;

  entry_t          ent_q [DEPTH];
  entry_t          ent_d [DEPTH];
  logic [CW-1:0]   count_q, count_d;
  logic [DEPTH-1:0] rdy;
  logic            sel_any;
  logic [IW-1:0]   sel_idx;
  entry_t          sel_e;
  entry_t          new_e;
  logic            deq, acc;
  logic [CW-1:0]   wr_idx;

  // Oldest-first select over registered state only.
  always_comb begin
    rdy     = '0;
    sel_any = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      rdy[i] = ent_q[i].valid & ent_q[i].rsvalid & ent_q[i].rtvalid;
    for (int i = DEPTH-1; i >= 0; i--)
      if (rdy[i]) begin
        sel_any = 1'b1;
        sel_idx = IW'(i);
      end
  end

  assign sel_e           = ent_q[sel_idx];
  assign issueint_ready  = sel_any;
  assign issueint_opcode = sel_any ? sel_e.opcode : '0;
  assign issueint_rsdata = sel_any ? sel_e.rsdata : '0;
  assign issueint_rtdata = sel_any ? sel_e.rtdata : '0;
  assign issueint_rdtag  = sel_any ? sel_e.rdtag  : '0;

  assign issueque_full  = (count_q == CW'(DEPTH));
  assign issueque_count = count_q;

  assign deq    = issueint_equeueint_done & sel_any;
  assign acc    = dispatch_en & ~issueque_full;
  assign wr_idx = count_q - CW'(deq);

  // New entry, with same-cycle CDB bypass for pending operands.
  always_comb begin
    new_e         = '0;
    new_e.valid   = 1'b1;
    new_e.opcode  = dispatch_opcode;
    new_e.rsdata  = dispatch_rsdata;
    new_e.rsvalid = dispatch_rsvalid;
    new_e.rstag   = dispatch_rstag;
    new_e.rtdata  = dispatch_rtdata;
    new_e.rtvalid = dispatch_rtvalid;
    new_e.rttag   = dispatch_rttag;
    new_e.rdtag   = dispatch_rdtag;
    if (cdb_valid && !dispatch_rsvalid && dispatch_rstag == cdb_tag) begin
      new_e.rsvalid = 1'b1;
      new_e.rsdata  = cdb_data;
    end
    if (cdb_valid && !dispatch_rtvalid && dispatch_rttag == cdb_tag) begin
      new_e.rtvalid = 1'b1;
      new_e.rtdata  = cdb_data;
    end
  end

  // Shift first, then wake on the shifted image so a moving entry never misses the CDB.
  always_comb begin
    entry_t sh;
    for (int i = 0; i < DEPTH; i++) begin
      if (deq && i >= int'(sel_idx))
        sh = (i < DEPTH-1) ? ent_q[(i+1) % DEPTH] : '0;
      else
        sh = ent_q[i];
      if (sh.valid && cdb_valid && !sh.rsvalid && sh.rstag == cdb_tag) begin
        sh.rsvalid = 1'b1;
        sh.rsdata  = cdb_data;
      end
      if (sh.valid && cdb_valid && !sh.rtvalid && sh.rttag == cdb_tag) begin
        sh.rtvalid = 1'b1;
        sh.rtdata  = cdb_data;
      end
      if (acc && CW'(i) == wr_idx)
        sh = new_e;
      if (flush)
        sh.valid = 1'b0;
      ent_d[i] = sh;
    end
    count_d = flush ? '0 : count_q + CW'(acc) - CW'(deq);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      count_q <= count_d;
    end
  end

endmodule
